// File: rtl/alureg_pkg.sv
// Shared encodings for the alureg_seq micro-sequencer: states, ALU ops, register indices, flag bits.
// Rotate decode is included only when ALUREG_SEQ_ROT_EN is defined.
package alureg_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_READ, ST_WRITE} state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_ANA, OP_XRA, OP_ORA, OP_CMP
  } alu_op_t;

  typedef enum logic [2:0] {K_NONE, K_MVI, K_MOV, K_ALU, K_RLC, K_RRC} kind_t;

  localparam logic [2:0] REG_B = 3'd0, REG_C = 3'd1, REG_D = 3'd2, REG_E = 3'd3,
                         REG_H = 3'd4, REG_L = 3'd5, REG_F = 3'd6, REG_A = 3'd7;

  localparam int FLG_C = 0, FLG_P = 1, FLG_Z = 2, FLG_S = 3;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] dst;
    logic [2:0] src;
    alu_op_t    op;
  } dec_t;

  // K_NONE is value 0, so a zeroed dec_t is an unsupported code.
  function automatic dec_t decode(input logic [7:0] c);
    dec_t d;
    d      = '0;
    d.dst  = c[5:3];
    d.src  = c[2:0];
    d.op   = alu_op_t'(c[5:3]);
    case (c[7:6])
      2'b00: begin
        if (c[2:0] == 3'b110) d.kind = K_MVI;
`ifdef ALUREG_SEQ_ROT_EN
        if (c == 8'h07) d.kind = K_RLC;
        if (c == 8'h0F) d.kind = K_RRC;
`endif
      end
      2'b01:   d.kind = K_MOV;
      2'b10:   d.kind = K_ALU;
      default: d.kind = K_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alureg_rfile.sv
// General-purpose register file: one async read port, one write port, async reset.
module alureg_rfile #(
  parameter int DATASIZE = 8,
  parameter int REGSBITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REGSBITS-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [REGSBITS-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  localparam int NREGS = 1 << REGSBITS;

  logic [NREGS-1:0][DATASIZE-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alureg_seq.sv
// Byte-fed register/ALU sequencer (MVI, MOV, 8-op ALU) with {S,Z,P,C} flags.
// Define ALUREG_SEQ_ROT_EN to add RLC/RRC; otherwise those codes retire with err.
module alureg_seq
  import alureg_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int REGSBITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [DATASIZE-1:0] in_dat,
  output logic                done,
  output logic                err,
  output logic [DATASIZE-1:0] res,
  output logic [3:0]          flg
);

  state_t              state, state_nxt;
  dec_t                dec, instr;
  logic [DATASIZE-1:0] tmp, acc, rf_rdata, src_val, wr_val;
  logic [3:0]          flags, flg_nxt;
  logic [DATASIZE:0]   a_x, b_x, c_x, sum;
  logic                acc_we, flg_we, rf_we;

  assign dec = decode(8'(in_dat));
  assign flg = flags;

  // A and F live here so the ALU can see A while the single rfile port reads s.
  alureg_rfile #(.DATASIZE(DATASIZE), .REGSBITS(REGSBITS)) u_rfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we && (state == ST_WRITE)),
    .waddr (REGSBITS'(instr.dst)),
    .wdata (wr_val),
    .raddr (REGSBITS'(instr.src)),
    .rdata (rf_rdata)
  );

  always_comb begin
    case (instr.src)
      REG_A:   src_val = acc;
      REG_F:   src_val = DATASIZE'(flags);
      default: src_val = rf_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          case (dec.kind)
            K_MVI:   state_nxt = ST_FETCH;
            K_NONE:  state_nxt = ST_WRITE;
            default: state_nxt = ST_READ;
          endcase
        end
      end
      ST_FETCH: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = ST_WRITE;
      end
      ST_READ:  state_nxt = ST_WRITE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign a_x = {1'b0, acc};
  assign b_x = {1'b0, tmp};
  assign c_x = {{DATASIZE{1'b0}}, flags[FLG_C]};

  always_comb begin
    sum     = '0;
    wr_val  = tmp;
    flg_nxt = flags;
    acc_we  = 1'b0;
    flg_we  = 1'b0;
    rf_we   = 1'b0;
    case (instr.kind)
      K_MVI, K_MOV: begin
        if (instr.dst == REG_A) acc_we = 1'b1;
        else if (instr.dst == REG_F) begin
          flg_we  = 1'b1;
          flg_nxt = tmp[3:0];
          wr_val  = DATASIZE'(tmp[3:0]);
        end else rf_we = 1'b1;
      end
      K_ALU: begin
        // Logic ops leave sum[DATASIZE]=0, which clears C.
        case (instr.op)
          OP_ADD:         sum = a_x + b_x;
          OP_ADC:         sum = a_x + b_x + c_x;
          OP_SUB, OP_CMP: sum = a_x - b_x;
          OP_SBB:         sum = a_x - b_x - c_x;
          OP_ANA:         sum = {1'b0, acc & tmp};
          OP_XRA:         sum = {1'b0, acc ^ tmp};
          OP_ORA:         sum = {1'b0, acc | tmp};
          default:        sum = '0;
        endcase
        wr_val         = sum[DATASIZE-1:0];
        flg_nxt[FLG_S] = sum[DATASIZE-1];
        flg_nxt[FLG_Z] = (sum[DATASIZE-1:0] == '0);
        flg_nxt[FLG_P] = ~^sum[DATASIZE-1:0];
        flg_nxt[FLG_C] = sum[DATASIZE];
        flg_we         = 1'b1;
        acc_we         = (instr.op != OP_CMP);
      end
`ifdef ALUREG_SEQ_ROT_EN
      K_RLC: begin
        wr_val         = {acc[DATASIZE-2:0], acc[DATASIZE-1]};
        flg_nxt[FLG_C] = acc[DATASIZE-1];
        acc_we         = 1'b1;
        flg_we         = 1'b1;
      end
      K_RRC: begin
        wr_val         = {acc[0], acc[DATASIZE-1:1]};
        flg_nxt[FLG_C] = acc[0];
        acc_we         = 1'b1;
        flg_we         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      tmp   <= '0;
      acc   <= '0;
      flags <= '0;
      res   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE && in_vld)  instr <= dec;
      if (state == ST_FETCH && in_vld) tmp   <= in_dat;
      if (state == ST_READ)            tmp   <= src_val;
      if (state == ST_WRITE) begin
        done <= 1'b1;
        err  <= (instr.kind == K_NONE);
        if (acc_we) acc   <= wr_val;
        if (flg_we) flags <= flg_nxt;
        if (instr.kind != K_NONE) res <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_alureg_seq.sv
// Directed bench for alureg_seq: 8-bit instance for the instruction set, 16-bit instance for width.
module tb_alureg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, in_rdy, done, err;
  logic [7:0]  in_dat, res;
  logic [3:0]  flg;
  logic        in_vld16, in_rdy16, done16, err16;
  logic [15:0] in_dat16, res16;
  logic [3:0]  flg16;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alureg_seq #(.DATASIZE(8), .REGSBITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .done(done), .err(err), .res(res), .flg(flg)
  );

  alureg_seq #(.DATASIZE(16), .REGSBITS(3)) u_dut16 (
    .clk(clk), .rst(rst), .in_vld(in_vld16), .in_rdy(in_rdy16), .in_dat(in_dat16),
    .done(done16), .err(err16), .res(res16), .flg(flg16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until the edge that transfers it; returns #1 after that edge.
  task automatic xfer(input logic [7:0] b, input string tag);
    int n;
    n      = 0;
    in_vld = 1'b1;
    in_dat = b;
    while (!in_rdy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " rdy"}, in_rdy, 1'b1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_dat = '0;
  endtask

  // done must stay low for lat-1 edges after the transfer edge and be high after the lat-th.
  task automatic retire(input string tag, input int lat, input bit cr,
                        input logic [7:0] r, input logic [3:0] f, input logic e);
    for (int i = 0; i < lat; i++) begin
      chk({tag, " early"}, done, 1'b0);
      @(posedge clk); #1;
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " err"}, err, e);
    if (cr) chk({tag, " res"}, res, r);
    chk({tag, " flg"}, flg, f);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_dat = '0;
    in_vld16 = 1'b0; in_dat16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst res", res, 8'h00);
    chk("rst flg", flg, 4'h0);
    chk("rst rdy", in_rdy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(8'h3E, "mvi a"); xfer(8'hAA, "mvi a imm");
    retire("mvi a", 1, 1, 8'hAA, 4'b0000, 0);
    xfer(8'h47, "mov b,a");
    chk("read rdy", in_rdy, 1'b0);
    retire("mov b,a", 2, 1, 8'hAA, 4'b0000, 0);
    xfer(8'h78, "mov a,b");  retire("mov a,b", 2, 1, 8'hAA, 4'b0000, 0);
    xfer(8'hAF, "xra a");    retire("xra a", 2, 1, 8'h00, 4'b0110, 0);
    @(posedge clk); #1;
    chk("idle done", done, 1'b0);
    chk("idle res", res, 8'h00);

    xfer(8'h3E, "mvi a2"); xfer(8'hF0, "mvi a2 imm");
    retire("mvi a2", 1, 1, 8'hF0, 4'b0110, 0);
    xfer(8'h06, "mvi b"); xfer(8'h20, "mvi b imm");
    retire("mvi b", 1, 1, 8'h20, 4'b0110, 0);
    xfer(8'h80, "add b");    retire("add b", 2, 1, 8'h10, 4'b0001, 0);
    xfer(8'hB8, "cmp b");    retire("cmp b", 2, 0, 8'h00, 4'b1011, 0);
    xfer(8'h7F, "mov a,a");  retire("mov a,a", 2, 1, 8'h10, 4'b1011, 0);
    xfer(8'h88, "adc b");    retire("adc b", 2, 1, 8'h31, 4'b0000, 0);
    xfer(8'h98, "sbb b c0"); retire("sbb b c0", 2, 1, 8'h11, 4'b0010, 0);
    xfer(8'hB8, "cmp b2");   retire("cmp b2", 2, 0, 8'h00, 4'b1001, 0);
    xfer(8'h98, "sbb b c1"); retire("sbb b c1", 2, 1, 8'hF0, 4'b1011, 0);
    xfer(8'hB0, "ora b");    retire("ora b", 2, 1, 8'hF0, 4'b1010, 0);
    xfer(8'hA0, "ana b");    retire("ana b", 2, 1, 8'h20, 4'b0000, 0);
    xfer(8'h97, "sub a");    retire("sub a", 2, 1, 8'h00, 4'b0110, 0);

    xfer(8'h36, "mvi f"); xfer(8'h05, "mvi f imm");
    retire("mvi f", 1, 1, 8'h05, 4'b0101, 0);
    xfer(8'h8E, "adc f");    retire("adc f", 2, 1, 8'h06, 4'b0010, 0);
    xfer(8'h36, "mvi f2"); xfer(8'hFF, "mvi f2 imm");
    retire("mvi f2", 1, 1, 8'h0F, 4'b1111, 0);
    xfer(8'h7E, "mov a,f");  retire("mov a,f", 2, 1, 8'h0F, 4'b1111, 0);

    xfer(8'hC3, "bad c3");   retire("bad c3", 1, 1, 8'h0F, 4'b1111, 1);
    xfer(8'h7F, "a kept");   retire("a kept", 2, 1, 8'h0F, 4'b1111, 0);
`ifdef ALUREG_SEQ_ROT_EN
    xfer(8'h36, "mvi f0"); xfer(8'h00, "mvi f0 imm");
    retire("mvi f0", 1, 1, 8'h00, 4'b0000, 0);
    xfer(8'h3E, "mvi a81"); xfer(8'h81, "mvi a81 imm");
    retire("mvi a81", 1, 1, 8'h81, 4'b0000, 0);
    xfer(8'h07, "rlc");      retire("rlc", 2, 1, 8'h03, 4'b0001, 0);
    xfer(8'h0F, "rrc");      retire("rrc", 2, 1, 8'h81, 4'b0001, 0);
`else
    xfer(8'h07, "bad 07");   retire("bad 07", 1, 1, 8'h0F, 4'b1111, 1);
    xfer(8'h0F, "bad 0f");   retire("bad 0f", 1, 1, 8'h0F, 4'b1111, 1);
    xfer(8'h7F, "a kept2");  retire("a kept2", 2, 1, 8'h0F, 4'b1111, 0);
`endif

    // Reset while waiting for the MVI C immediate.
    xfer(8'h0E, "mvi c");
    chk("fetch rdy", in_rdy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst done", done, 1'b0);
    chk("arst flg", flg, 4'h0);
    chk("arst res", res, 8'h00);
    chk("arst rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post rst done", done, 1'b0);
    chk("post rst rdy", in_rdy, 1'b1);
    xfer(8'h79, "mov a,c");  retire("mov a,c", 2, 1, 8'h00, 4'b0000, 0);

    // 16-bit instance: MVI A,FFFF; MVI B,0001; ADD B.
    chk("w16 rdy", in_rdy16, 1'b1);
    in_vld16 = 1'b1; in_dat16 = 16'h003E; @(posedge clk); #1;
    in_dat16 = 16'hFFFF;                  @(posedge clk); #1;
    in_vld16 = 1'b0;                      @(posedge clk); #1;
    chk("w16 mvi a done", done16, 1'b1);
    chk("w16 mvi a res", res16, 16'hFFFF);
    in_vld16 = 1'b1; in_dat16 = 16'h0006; @(posedge clk); #1;
    in_dat16 = 16'h0001;                  @(posedge clk); #1;
    in_vld16 = 1'b0;                      @(posedge clk); #1;
    chk("w16 mvi b res", res16, 16'h0001);
    in_vld16 = 1'b1; in_dat16 = 16'h0080; @(posedge clk); #1;
    in_vld16 = 1'b0;
    chk("w16 add early", done16, 1'b0);
    @(posedge clk); #1;
    chk("w16 add early2", done16, 1'b0);
    @(posedge clk); #1;
    chk("w16 add done", done16, 1'b1);
    chk("w16 add err", err16, 1'b0);
    chk("w16 add res", res16, 16'h0000);
    chk("w16 add flg", flg16, 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
